// File: rtl/doce_rx_pkg.sv
// Shared types and constants for the DoCE RX channel demultiplexer.
// Holds the FSM state encoding, header field positions and the saturating counter helper.
package doce_rx_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int MAC_HI  = 95;
  localparam int MAC_LO  = 48;
  localparam int CNT_W   = 16;
  // Channel ids are range-checked over this many bits so out-of-range ids cannot alias onto a real channel.
  localparam int CHAN_FW = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Small registered FIFO used as the payload skid buffer.
// Head entry is driven straight from storage so downstream sees only registered data.
module axis_skid_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             user_clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;
  assign full       = (count_reg == CW'(DEPTH));
  assign head_valid = (count_reg != '0);
  assign head_data  = mem_reg[rd_ptr_reg];

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rx_chan_demux_fsm.sv
// DoCE RX transport FSM: absorbs the header beat, filters bad packets and
// demultiplexes payload beats to one-hot channel outputs through a 2-entry skid.
module rx_chan_demux_fsm
  import doce_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHAN   = 4,
  parameter int CHAN_LSB   = 112,
  parameter int USER_WIDTH = 4,
  parameter int DROP_BIT   = 2
) (
  input  logic                    user_clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH*8-1:0] s_tdata,
  input  logic [DATA_WIDTH-1:0]   s_tkeep,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH*8-1:0] m_tdata,
  output logic [DATA_WIDTH-1:0]   m_tkeep,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic                    m_tlast,
  output logic [NUM_CHAN-1:0]     m_tvalid,
  input  logic [NUM_CHAN-1:0]     m_tready,
  output logic [47:0]             rx_dst_mac_addr,
  output logic                    rx_hdr_pulse,
  output logic [CNT_W-1:0]        pkt_cnt,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int DW = DATA_WIDTH * 8;
  localparam int EW = DW + DATA_WIDTH + 1 + USER_WIDTH + CW;

  state_e                state_reg, state_next;
  logic                  active_reg;
  logic [47:0]           mac_reg;
  logic [USER_WIDTH-1:0] tuser_reg;
  logic [CW-1:0]         chan_reg;
  logic                  hdr_pulse_reg;
  logic [CNT_W-1:0]      pkt_cnt_reg;
  logic [CNT_W-1:0]      drop_cnt_reg;

  logic                  hdr_accept, runt, pay_push, drop_done, hdr_bad;
  logic                  skid_full, skid_valid, skid_pop;
  logic [CHAN_FW-1:0]    hdr_chan_id;
  logic [EW-1:0]         push_data, head_data;
  logic [DW-1:0]         head_tdata;
  logic [DATA_WIDTH-1:0] head_tkeep;
  logic                  head_tlast;
  logic [USER_WIDTH-1:0] head_tuser;
  logic [CW-1:0]         head_chan;

  assign hdr_chan_id = s_tdata[CHAN_LSB +: CHAN_FW];
  assign hdr_bad     = s_tuser[DROP_BIT] || (int'(hdr_chan_id) >= NUM_CHAN);

  always_comb begin
    state_next = state_reg;
    s_tready   = 1'b0;
    hdr_accept = 1'b0;
    runt       = 1'b0;
    pay_push   = 1'b0;
    drop_done  = 1'b0;
    case (state_reg)
      HDR: begin
        s_tready = active_reg;
        if (s_tvalid && active_reg) begin
          hdr_accept = 1'b1;
          if (s_tlast)      runt       = 1'b1;
          else if (hdr_bad) state_next = DROP;
          else              state_next = PAY;
        end
      end
      PAY: begin
        s_tready = active_reg && !skid_full;
        if (s_tvalid && active_reg && !skid_full) begin
          pay_push = 1'b1;
          if (s_tlast) state_next = HDR;
        end
      end
      DROP: begin
        s_tready = active_reg;
        if (s_tvalid && active_reg && s_tlast) begin
          drop_done  = 1'b1;
          state_next = HDR;
        end
      end
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= HDR;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= 1'b1;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_reg       <= '0;
      tuser_reg     <= '0;
      chan_reg      <= '0;
      hdr_pulse_reg <= 1'b0;
      pkt_cnt_reg   <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      hdr_pulse_reg <= hdr_accept;
      if (hdr_accept) begin
        mac_reg   <= s_tdata[MAC_HI:MAC_LO];
        tuser_reg <= s_tuser;
        chan_reg  <= s_tdata[CHAN_LSB +: CW];
      end
      if (runt || drop_done)      drop_cnt_reg <= sat_inc(drop_cnt_reg);
      if (skid_pop && head_tlast) pkt_cnt_reg  <= sat_inc(pkt_cnt_reg);
    end
  end

  // Channel and tuser travel with each beat so a new header can be taken while the old tail drains.
  assign push_data = {s_tdata, s_tkeep, s_tlast, tuser_reg, chan_reg};
  assign {head_tdata, head_tkeep, head_tlast, head_tuser, head_chan} = head_data;

  axis_skid_buf #(
    .WIDTH (EW),
    .DEPTH (2)
  ) u_skid (
    .user_clk   (user_clk),
    .reset_n    (reset_n),
    .push       (pay_push),
    .push_data  (push_data),
    .full       (skid_full),
    .pop        (skid_pop),
    .head_data  (head_data),
    .head_valid (skid_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHAN; gi++) begin : g_valid
      assign m_tvalid[gi] = skid_valid && (head_chan == CW'(gi));
    end
  endgenerate

  assign skid_pop        = |(m_tvalid & m_tready);
  assign m_tdata         = head_tdata;
  assign m_tkeep         = head_tkeep;
  assign m_tlast         = head_tlast;
  assign m_tuser         = head_tuser;
  assign rx_dst_mac_addr = mac_reg;
  assign rx_hdr_pulse    = hdr_pulse_reg;
  assign pkt_cnt         = pkt_cnt_reg;
  assign drop_cnt        = drop_cnt_reg;

endmodule

// File: tb/tb_rx_chan_demux_fsm.sv
// Directed bench for rx_chan_demux_fsm: header handling, drops, demux, backpressure and reset.
module tb_rx_chan_demux_fsm;

  logic         user_clk = 1'b0;
  logic         reset_n  = 1'b0;
  logic [127:0] s_tdata  = '0;
  logic [15:0]  s_tkeep  = '0;
  logic [3:0]   s_tuser  = '0;
  logic         s_tlast  = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic [3:0]   m_tuser;
  logic         m_tlast;
  logic [3:0]   m_tvalid;
  logic [3:0]   m_tready = 4'hF;
  logic [47:0]  rx_dst_mac_addr;
  logic         rx_hdr_pulse;
  logic [15:0]  pkt_cnt;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int passes = 0;
  int vld_cycles = 0;
  int stall_acc = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [3:0]   user;
    int           chan;
  } rec_t;
  rec_t got_q[$];

  always #5 user_clk = ~user_clk;

  rx_chan_demux_fsm #(
    .DATA_WIDTH (16),
    .NUM_CHAN   (4),
    .CHAN_LSB   (112),
    .USER_WIDTH (4),
    .DROP_BIT   (2)
  ) dut (
    .user_clk        (user_clk),
    .reset_n         (reset_n),
    .s_tdata         (s_tdata),
    .s_tkeep         (s_tkeep),
    .s_tuser         (s_tuser),
    .s_tlast         (s_tlast),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .m_tdata         (m_tdata),
    .m_tkeep         (m_tkeep),
    .m_tuser         (m_tuser),
    .m_tlast         (m_tlast),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .rx_dst_mac_addr (rx_dst_mac_addr),
    .rx_hdr_pulse    (rx_hdr_pulse),
    .pkt_cnt         (pkt_cnt),
    .drop_cnt        (drop_cnt)
  );

  // Output monitor: records every completed output handshake.
  always @(negedge user_clk) begin
    if (reset_n) begin
      if (|m_tvalid) vld_cycles++;
      if (!m_tready[2] && s_tvalid && s_tready) stall_acc++;
      for (int c = 0; c < 4; c++) begin
        if (m_tvalid[c] && m_tready[c]) begin
          got_q.push_back('{m_tdata, m_tlast, m_tuser, c});
          $display("out ch%0d data=%h last=%0b user=%h", c, m_tdata, m_tlast, m_tuser);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500us");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] hdr(input logic [47:0] mac, input logic [3:0] ch);
    logic [127:0] d;
    d = '0;
    d[95:48]   = mac;
    d[115:112] = ch;
    return d;
  endfunction

  function automatic logic [127:0] pay(input int i);
    logic [15:0] w;
    w = 16'hA000 + 16'(i);
    return {8{w}};
  endfunction

  task automatic send_beat(input logic [127:0] d, input logic [3:0] u, input logic l);
    int n;
    n = 0;
    s_tdata = d; s_tkeep = 16'hFFFF; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    @(negedge user_clk);
    while (!s_tready && n < 50) begin
      stall_cnt++;
      n++;
      @(negedge user_clk);
    end
    if (!s_tready) begin
      checks++;
      $display("FAIL send_timeout: got s_tready=0 after %0d cycles, expected 1", n);
    end
    @(posedge user_clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    $display("in  data=%h user=%h last=%0b waits=%0d", d, u, l, n);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; s_tvalid = 1'b0; m_tready = 4'hF;
    repeat (2) @(posedge user_clk);
    @(negedge user_clk) reset_n = 1'b1;
    @(posedge user_clk); #1;
    got_q.delete();
    vld_cycles = 0; stall_acc = 0; stall_cnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge user_clk);
    #1;
    checks++;
    if ({s_tready, m_tvalid, rx_hdr_pulse} !== 6'b0) $display("FAIL reset_ctrl: got %b expected 000000", {s_tready, m_tvalid, rx_hdr_pulse});
    else passes++;
    checks++;
    if (pkt_cnt !== 16'd0 || drop_cnt !== 16'd0 || rx_dst_mac_addr !== 48'd0)
      $display("FAIL reset_regs: got pkt=%0d drop=%0d mac=%h expected 0 0 0", pkt_cnt, drop_cnt, rx_dst_mac_addr);
    else passes++;
    do_reset();
    checks++;
    if (s_tready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", s_tready);
    else passes++;
  endtask

  task automatic test_forward();
    do_reset();
    s_tdata = hdr(48'h0A1B2C3D4E5F, 4'd1); s_tkeep = 16'hFFFF; s_tuser = 4'h0; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge user_clk);
    checks++;
    if (m_tvalid !== 4'b0000) $display("FAIL fwd_c0_valid: got %b expected 0000", m_tvalid); else passes++;
    @(posedge user_clk); #1;
    s_tdata = pay(1);
    @(negedge user_clk);
    checks++;
    if (m_tvalid !== 4'b0000 || rx_hdr_pulse !== 1'b1)
      $display("FAIL fwd_c1: got valid=%b pulse=%b expected 0000 1", m_tvalid, rx_hdr_pulse); else passes++;
    @(posedge user_clk); #1;
    s_tdata = pay(2);
    @(negedge user_clk);
    checks++;
    if (m_tvalid !== 4'b0010 || m_tdata !== pay(1) || rx_hdr_pulse !== 1'b0)
      $display("FAIL fwd_c2: got valid=%b data=%h pulse=%b expected 0010 %h 0", m_tvalid, m_tdata, rx_hdr_pulse, pay(1)); else passes++;
    @(posedge user_clk); #1;
    s_tdata = pay(3); s_tlast = 1'b1;
    @(negedge user_clk);
    checks++;
    if (m_tvalid !== 4'b0010 || m_tdata !== pay(2) || m_tlast !== 1'b0)
      $display("FAIL fwd_c3: got valid=%b data=%h last=%b expected 0010 %h 0", m_tvalid, m_tdata, m_tlast, pay(2)); else passes++;
    @(posedge user_clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge user_clk);
    checks++;
    if (m_tvalid !== 4'b0010 || m_tdata !== pay(3) || m_tlast !== 1'b1)
      $display("FAIL fwd_c4: got valid=%b data=%h last=%b expected 0010 %h 1", m_tvalid, m_tdata, m_tlast, pay(3)); else passes++;
    @(posedge user_clk); #1;
    @(negedge user_clk);
    checks++;
    if (m_tvalid !== 4'b0000 || pkt_cnt !== 16'd1)
      $display("FAIL fwd_c5: got valid=%b pkt=%0d expected 0000 1", m_tvalid, pkt_cnt); else passes++;
    checks++;
    if (rx_dst_mac_addr !== 48'h0A1B2C3D4E5F)
      $display("FAIL fwd_mac: got %h expected 0a1b2c3d4e5f", rx_dst_mac_addr); else passes++;
  endtask

  task automatic test_drop_tuser();
    do_reset();
    send_beat(hdr(48'h111111111111, 4'd1), 4'b0100, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(pay(i), 4'h0, i == 3);
    drain(3);
    checks++;
    if (vld_cycles != 0 || drop_cnt !== 16'd1 || pkt_cnt !== 16'd0)
      $display("FAIL drop_tuser: got vld=%0d drop=%0d pkt=%0d expected 0 1 0", vld_cycles, drop_cnt, pkt_cnt); else passes++;
    checks++;
    if (stall_cnt != 0) $display("FAIL drop_tuser_ready: got %0d stall cycles expected 0", stall_cnt); else passes++;
  endtask

  task automatic test_bad_chan();
    do_reset();
    send_beat(hdr(48'h222222222222, 4'd5), 4'h0, 1'b0);
    send_beat(pay(7), 4'h0, 1'b0);
    send_beat(pay(8), 4'h0, 1'b1);
    send_beat(hdr(48'h333333333333, 4'd0), 4'h0, 1'b0);
    send_beat(pay(9), 4'h0, 1'b0);
    send_beat(pay(10), 4'h0, 1'b1);
    drain(4);
    checks++;
    if (drop_cnt !== 16'd1 || pkt_cnt !== 16'd1 || got_q.size() != 2)
      $display("FAIL bad_chan_counts: got drop=%0d pkt=%0d beats=%0d expected 1 1 2", drop_cnt, pkt_cnt, got_q.size()); else passes++;
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      checks++;
      if (got_q[i].data !== pay(9 + i) || got_q[i].chan != 0 || got_q[i].last !== (i == 1))
        $display("FAIL bad_chan_beat%0d: got %h ch%0d last=%b expected %h ch0 last=%b", i, got_q[i].data, got_q[i].chan, got_q[i].last, pay(9 + i), (i == 1));
      else passes++;
    end
  endtask

  task automatic test_runt();
    do_reset();
    send_beat(hdr(48'h444444444444, 4'd1), 4'h0, 1'b1);
    @(negedge user_clk);
    checks++;
    if (drop_cnt !== 16'd1 || s_tready !== 1'b1)
      $display("FAIL runt_drop: got drop=%0d ready=%b expected 1 1", drop_cnt, s_tready); else passes++;
    @(posedge user_clk); #1;
    send_beat(hdr(48'h555555555555, 4'd3), 4'h9, 1'b0);
    send_beat(pay(40), 4'h0, 1'b1);
    drain(3);
    checks++;
    if (got_q.size() != 1 || rx_dst_mac_addr !== 48'h555555555555 || pkt_cnt !== 16'd1)
      $display("FAIL runt_next: got beats=%0d mac=%h pkt=%0d expected 1 555555555555 1", got_q.size(), rx_dst_mac_addr, pkt_cnt); else passes++;
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0].data !== pay(40) || got_q[0].chan != 3 || got_q[0].user !== 4'h9)
        $display("FAIL runt_beat: got %h ch%0d user=%h expected %h ch3 user=9", got_q[0].data, got_q[0].chan, got_q[0].user, pay(40)); else passes++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fork
      begin
        send_beat(hdr(48'h666666666666, 4'd2), 4'h0, 1'b0);
        for (int i = 0; i < 6; i++) send_beat(pay(10 + i), 4'h0, i == 5);
      end
      begin
        repeat (2) @(posedge user_clk);
        #2 m_tready[2] = 1'b0;
        repeat (5) @(posedge user_clk);
        #2 m_tready[2] = 1'b1;
      end
    join
    drain(4);
    checks++;
    if (stall_cnt == 0 || stall_acc > 2)
      $display("FAIL bp_ready: got stalls=%0d accepted_while_blocked=%0d expected >0 and <=2", stall_cnt, stall_acc); else passes++;
    checks++;
    if (got_q.size() != 6 || pkt_cnt !== 16'd1)
      $display("FAIL bp_count: got beats=%0d pkt=%0d expected 6 1", got_q.size(), pkt_cnt); else passes++;
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      checks++;
      if (got_q[i].data !== pay(10 + i) || got_q[i].chan != 2 || got_q[i].last !== (i == 5))
        $display("FAIL bp_beat%0d: got %h ch%0d last=%b expected %h ch2 last=%b", i, got_q[i].data, got_q[i].chan, got_q[i].last, pay(10 + i), (i == 5));
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_beat(hdr(48'h777777777777, 4'd0), 4'h0, 1'b0);
    send_beat(pay(50), 4'h0, 1'b0);
    send_beat(pay(51), 4'h0, 1'b1);
    send_beat(hdr(48'h888888888888, 4'd1), 4'h0, 1'b0);
    send_beat(pay(52), 4'h0, 1'b0);
    send_beat(pay(53), 4'h0, 1'b1);
    drain(4);
    checks++;
    if (stall_cnt != 0 || vld_cycles != 4 || pkt_cnt !== 16'd2 || got_q.size() != 4)
      $display("FAIL b2b: got stalls=%0d vld=%0d pkt=%0d beats=%0d expected 0 4 2 4", stall_cnt, vld_cycles, pkt_cnt, got_q.size()); else passes++;
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i].data !== pay(50 + i) || got_q[i].chan != i / 2)
        $display("FAIL b2b_beat%0d: got %h ch%0d expected %h ch%0d", i, got_q[i].data, got_q[i].chan, pay(50 + i), i / 2);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_beat(hdr(48'h999999999999, 4'd1), 4'h0, 1'b0);
    send_beat(pay(60), 4'h0, 1'b1);
    drain(3);
    checks++;
    if (pkt_cnt !== 16'd1) $display("FAIL rst_mid_pre: got pkt=%0d expected 1", pkt_cnt); else passes++;
    m_tready = 4'b1101;
    send_beat(hdr(48'hAAAAAAAAAAAA, 4'd1), 4'h0, 1'b0);
    send_beat(pay(20), 4'h0, 1'b0);
    send_beat(pay(21), 4'h0, 1'b0);
    s_tdata = pay(22); s_tvalid = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 4'b0000 || s_tready !== 1'b0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0)
      $display("FAIL rst_mid_async: got valid=%b ready=%b pkt=%0d drop=%0d expected 0000 0 0 0", m_tvalid, s_tready, pkt_cnt, drop_cnt); else passes++;
    s_tvalid = 1'b0;
    do_reset();
    send_beat(hdr(48'hBBBBBBBBBBBB, 4'd3), 4'h0, 1'b0);
    send_beat(pay(30), 4'h0, 1'b0);
    send_beat(pay(31), 4'h0, 1'b1);
    drain(3);
    checks++;
    if (got_q.size() != 2 || pkt_cnt !== 16'd1 || rx_dst_mac_addr !== 48'hBBBBBBBBBBBB)
      $display("FAIL rst_mid_fresh: got beats=%0d pkt=%0d mac=%h expected 2 1 bbbbbbbbbbbb", got_q.size(), pkt_cnt, rx_dst_mac_addr); else passes++;
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      checks++;
      if (got_q[i].data !== pay(30 + i) || got_q[i].chan != 3)
        $display("FAIL rst_mid_beat%0d: got %h ch%0d expected %h ch3", i, got_q[i].data, got_q[i].chan, pay(30 + i));
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_drop_tuser();
    test_bad_chan();
    test_runt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
